param_load_ctrl: RTL and testbench

PARAM_LOAD_CTRL -- requirements
Module: param_load_ctrl

---
 rtl/param_load_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_param_load_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/param_load_ctrl.sv
// param_load_ctrl: routes bus write beats into per-channel parameter memories
// (ch0 pixel, ch1 weight, ch2 bias) layer by layer.
//
// Each channel walks IDLE -> LOAD -> FINISH. It counts written beats against a
// per-layer programmable length. It pulses layer_done after each layer and
// parks in FINISH once its last layer is loaded. irq fires when every channel
// has finished.
//
// Optional feature macro: LOAD_ERR_CHECK_EN. When it is defined, err is a
// sticky flag. It sets on a beat to a finished channel or on a rejected config
// write, and it clears together with irq.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   awaddr, awvalid   write address; region decode, config and irq-clear hits
//   wdata, wvalid     write data; wvalid qualifies memory beats
//   mem_we            one-hot memory write strobe per channel
//   mem_addr          word address within the current layer
//   mem_data          write data (wdata[DATA_W-1:0])
//   layer_done        one-cycle pulse per completed layer, per channel
//   layer_sel         current layer index, 4 bits per channel
//   ch_finish         level: channel has loaded all its layers
//   irq               all-channels-finished interrupt, cleared by IRQ_ADDR write
//   err               sticky load/config error (0 unless LOAD_ERR_CHECK_EN)
module param_load_ctrl #(
  parameter int unsigned NUM_CH      = 3,
  parameter int unsigned NUM_LAYERS  = 4,
  parameter int unsigned DATA_W      = 16,
  parameter logic [15:0] REGION_BASE = 16'hd333,
  parameter logic [31:0] CFG_ADDR    = 32'hd111_0004,
  parameter logic [31:0] IRQ_ADDR    = 32'hd222_0000,
  parameter logic [15:0] DEFAULT_LEN = 16'd8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         awaddr,
  input  logic                awvalid,
  input  logic [31:0]         wdata,
  input  logic                wvalid,
  output logic [NUM_CH-1:0]   mem_we,
  output logic [15:0]         mem_addr,
  output logic [DATA_W-1:0]   mem_data,
  output logic [NUM_CH-1:0]   layer_done,
  output logic [NUM_CH*4-1:0] layer_sel,
  output logic [NUM_CH-1:0]   ch_finish,
  output logic                irq,
  output logic                err
);

  typedef enum logic [1:0] {StIdle, StLoad, StFinish} state_e;

  state_e      state_q [NUM_CH];
  state_e      state_d [NUM_CH];
  logic [15:0] count_q [NUM_CH];
  logic [3:0]  layer_q [NUM_CH];
  logic [15:0] len_q   [NUM_CH][NUM_LAYERS];
  logic [15:0] cur_len [NUM_CH];

  logic [NUM_CH-1:0] beat;
  logic [NUM_CH-1:0] wr;
  logic [NUM_CH-1:0] last;
  logic [NUM_CH-1:0] last_layer;
  logic [NUM_CH-1:0] done_q;

  logic cfg_hit;
  logic cfg_ch_idle;
  logic cfg_ly_ok;
  logic cfg_we;
  logic irq_clr;
  logic all_fin;
  logic all_fin_q;
  logic irq_q;

  // Length field sits in wdata[15:0]; bits 23:16 of a config word carry nothing.
  logic unused_wdata;
  assign unused_wdata = ^wdata[23:16];

  // Beat decode and end-of-layer detection. Layer lookups use compare loops so
  // the 4-bit layer index never has to match the array depth.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      beat[c]    = wvalid && (awaddr[31:16] == (REGION_BASE + 16'(c)));
      wr[c]      = beat[c] && (state_q[c] != StFinish);
      cur_len[c] = '0;
      for (int l = 0; l < NUM_LAYERS; l++) begin
        if (layer_q[c] == 4'(l)) cur_len[c] = len_q[c][l];
      end
      last_layer[c] = (layer_q[c] == 4'(NUM_LAYERS - 1));
      last[c]       = wr[c] && (count_q[c] == (cur_len[c] - 16'd1));
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= StIdle;
    end else begin
      for (int c = 0; c < NUM_CH; c++) state_q[c] <= state_d[c];
    end
  end

  // FSM next state
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      case (state_q[c])
        StIdle, StLoad: begin
          if (last[c] && last_layer[c]) state_d[c] = StFinish;
          else if (wr[c])               state_d[c] = StLoad;
        end
        StFinish: state_d[c] = StFinish;
        default:  state_d[c] = StIdle;
      endcase
    end
  end

  // FSM outputs. Beats never target two channels at once, so OR-merging the
  // per-channel address is a plain mux.
  always_comb begin
    mem_we   = wr;
    mem_addr = '0;
    mem_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (wr[c]) mem_addr = mem_addr | count_q[c];
      ch_finish[c]        = (state_q[c] == StFinish);
      layer_sel[c*4 +: 4] = layer_q[c];
    end
    if (|wr) mem_data = wdata[DATA_W-1:0];
  end

  assign layer_done = done_q;

  // Word counter and layer index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        count_q[c] <= '0;
        layer_q[c] <= '0;
      end
      done_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (last[c])    count_q[c] <= '0;
        else if (wr[c]) count_q[c] <= count_q[c] + 16'd1;
        // On the final layer the index stays parked at NUM_LAYERS-1.
        if (last[c] && !last_layer[c]) layer_q[c] <= layer_q[c] + 4'd1;
      end
      done_q <= last;
    end
  end

  // Config write: {ch[31:28], layer[27:24], len[15:0]}. It only takes effect
  // on an idle channel with in-range indices and a non-zero length.
  always_comb begin
    cfg_hit     = awvalid && (awaddr == CFG_ADDR);
    cfg_ch_idle = 1'b0;
    cfg_ly_ok   = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((wdata[31:28] == 4'(c)) && (state_q[c] == StIdle)) cfg_ch_idle = 1'b1;
    end
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (wdata[27:24] == 4'(l)) cfg_ly_ok = 1'b1;
    end
    cfg_we = cfg_hit && cfg_ch_idle && cfg_ly_ok && (wdata[15:0] != 16'd0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int l = 0; l < NUM_LAYERS; l++) len_q[c][l] <= DEFAULT_LEN;
      end
    end else if (cfg_we) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int l = 0; l < NUM_LAYERS; l++) begin
          if ((wdata[31:28] == 4'(c)) && (wdata[27:24] == 4'(l))) len_q[c][l] <= wdata[15:0];
        end
      end
    end
  end

  // irq sets on the rising edge of "all finished". ch_finish stays high until
  // reset, so a level-triggered set would make the clear write useless.
  assign all_fin = &ch_finish;
  assign irq_clr = awvalid && (awaddr == IRQ_ADDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      all_fin_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      all_fin_q <= all_fin;
      if (all_fin && !all_fin_q) irq_q <= 1'b1;
      else if (irq_clr)          irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;

`ifdef LOAD_ERR_CHECK_EN
  logic err_q;
  logic err_set;

  assign err_set = (|(beat & ~wr)) || (cfg_hit && !cfg_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
    else if (irq_clr) err_q <= 1'b0;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_param_load_ctrl.sv
// Self-checking bench for param_load_ctrl using randomized directed steps.
// A per-channel behavioural model predicts every output.
module tb_param_load_ctrl;
  localparam logic [31:0] CFG  = 32'hd111_0004;
  localparam logic [31:0] IRQA = 32'hd222_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic [31:0] wdata = '0;
  logic        wvalid = 1'b0;
  logic [2:0]  mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [2:0]  layer_done;
  logic [11:0] layer_sel;
  logic [2:0]  ch_finish;
  logic        irq;
  logic        err;

  always #5 clk = ~clk;

  param_load_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .awaddr    (awaddr),
    .awvalid   (awvalid),
    .wdata     (wdata),
    .wvalid    (wvalid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .layer_done(layer_done),
    .layer_sel (layer_sel),
    .ch_finish (ch_finish),
    .irq       (irq),
    .err       (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: words loaded, current layer, lengths, finished flags.
  int         cnt     [3];
  int         lay     [3];
  int         ln      [3][4];
  bit         fin     [3];
  bit         started [3];
  bit         m_irq, m_pend, m_err;
  logic [2:0] m_done;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      cnt[c] = 0; lay[c] = 0; fin[c] = 0; started[c] = 0;
      for (int l = 0; l < 4; l++) ln[c][l] = 8;
    end
    m_irq = 0; m_pend = 0; m_err = 0; m_done = '0;
  endtask

  function automatic bit all_fin();
    return fin[0] && fin[1] && fin[2];
  endfunction

  // One bus cycle. The task is entered 1 time unit after a rising edge. It
  // checks combinational outputs before the next edge and registered outputs
  // just after it.
  task automatic cycle(input logic [31:0] a, input logic av, input logic [31:0] d,
                       input logic wv);
    bit         is_beat, old_all, clr, e_set, ok;
    int         ch, cc, cl, v;
    logic [2:0] e_we;
    logic [15:0] e_addr, e_data;
    awaddr = a; awvalid = av; wdata = d; wvalid = wv;
    is_beat = wv && (a[31:16] >= 16'hd333) && (a[31:16] <= 16'hd335);
    ch = is_beat ? int'(a[31:16] - 16'hd333) : 0;
    e_we = '0; e_addr = '0; e_data = '0;
    if (is_beat && !fin[ch]) begin
      e_we = 3'(1 << ch); e_addr = 16'(cnt[ch]); e_data = d[15:0];
    end
    #3;
    check("mem_we", 64'(mem_we), 64'(e_we));
    check("mem_addr", 64'(mem_addr), 64'(e_addr));
    check("mem_data", 64'(mem_data), 64'(e_data));
    @(posedge clk); #1;
    old_all = all_fin();
    e_set = 0; m_done = '0;
    clr = av && (a == IRQA);
    if (av && (a == CFG)) begin
      cc = int'(d[31:28]); cl = int'(d[27:24]); v = int'(d[15:0]);
      ok = (cc < 3) && (cl < 4) && (v != 0);
      if (ok && started[cc]) ok = 0;
      if (ok) ln[cc][cl] = v;
      else e_set = 1;
    end
    if (is_beat) begin
      if (fin[ch]) e_set = 1;
      else begin
        started[ch] = 1;
        if (cnt[ch] + 1 == ln[ch][lay[ch]]) begin
          cnt[ch] = 0; m_done[ch] = 1'b1;
          if (lay[ch] == 3) fin[ch] = 1;
          else lay[ch]++;
        end else cnt[ch]++;
      end
    end
    if (m_pend) begin m_irq = 1; m_pend = 0; end
    else if (clr) m_irq = 0;
    if (!old_all && all_fin()) m_pend = 1;
`ifdef LOAD_ERR_CHECK_EN
    if (e_set) m_err = 1;
    else if (clr) m_err = 0;
`else
    if (e_set || clr) m_err = 0;
`endif
    check("layer_done", 64'(layer_done), 64'(m_done));
    check("layer_sel", 64'(layer_sel), 64'({4'(lay[2]), 4'(lay[1]), 4'(lay[0])}));
    check("ch_finish", 64'(ch_finish), 64'({fin[2], fin[1], fin[0]}));
    check("irq", 64'(irq), 64'(m_irq));
    check("err", 64'(err), 64'(m_err));
  endtask

  task automatic beat(input int ch, input logic [31:0] d);
    logic [15:0] hi;
    hi = 16'hd333 + 16'(ch);
    cycle({hi, 16'($urandom)}, 1'($urandom), d, 1'b1);
  endtask

  // Beat-like traffic outside the channel regions, including the boundaries.
  task automatic idle();
    logic [15:0] hi;
    case ($urandom_range(0, 2))
      0:       hi = 16'h1234;
      1:       hi = 16'hd332;
      default: hi = 16'hd336;
    endcase
    cycle({hi, 16'($urandom)}, 1'($urandom), $urandom, 1'($urandom));
  endtask

  task automatic cfg(input int ch, input int l, input int len);
    cycle(CFG, 1'b1, {4'(ch), 4'(l), 8'h00, 16'(len)}, 1'b0);
  endtask

  task automatic irq_clear();
    cycle(IRQA, 1'b1, $urandom, 1'b0);
  endtask

  // rst rises between edges, so the zero checks observe its asynchronous action.
  task automatic do_reset();
    awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0;
    rst = 1'b1;
    #2;
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_layer_done", 64'(layer_done), 64'(0));
    check("rst_layer_sel", 64'(layer_sel), 64'(0));
    check("rst_ch_finish", 64'(ch_finish), 64'(0));
    check("rst_irq", 64'(irq), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done_all;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Default lengths: eight beats to ch1 with data 1..8.
    for (int i = 1; i <= 8; i++) beat(1, 32'(i));
    idle();
    idle();

    // ch1 layer0 programmed to 216 while idle, with stray traffic mixed in.
    do_reset();
    cfg(1, 0, 216);
    for (int i = 0; i < 216; i++) begin
      beat(1, $urandom);
      if ($urandom_range(0, 3) == 0) idle();
    end
    for (int i = 0; i < 8; i++) beat(1, $urandom);

    // Rejected config writes: zero length, bad channel, bad layer, busy channel.
    do_reset();
    cfg(0, 0, 0);
    cfg(5, 0, 10);
    cfg(0, 7, 10);
    cfg(0, 1, 3);
    for (int i = 0; i < 3; i++) beat(0, $urandom);
    cfg(0, 0, 2);
    for (int i = 0; i < 8; i++) beat(0, $urandom);

    // Run every channel to FINISH in random order, with extra beats to
    // finished channels along the way.
    done_all = 0;
    for (int i = 0; i < 3000; i++) begin
      beat($urandom_range(0, 2), $urandom);
      if (all_fin()) begin
        done_all = 1;
        break;
      end
      if ($urandom_range(0, 4) == 0) idle();
    end
    check("load_all_in_budget", 64'(done_all), 64'(1));
    irq_clear();      // coincides with the irq set edge; the set must win
    beat(0, $urandom);
    beat(2, $urandom);
    idle();
    irq_clear();
    idle();

    // Reset part way through a ch0 load.
    do_reset();
    for (int i = 0; i < 5; i++) beat(0, $urandom);
    do_reset();
    for (int i = 0; i < 10; i++) beat(0, $urandom);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
